// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : frame width, parity constants and FSM encoding shared by UART.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int   c_DATA_W   = 8;
  localparam logic c_PAR_EVEN = 1'b0;
  localparam logic c_PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Expected parity bit for a data byte under the selected parity type.
  function automatic logic f_parity(input logic [c_DATA_W-1:0] data, input logic par_typ);
    return (par_typ == c_PAR_EVEN) ? (^data) : ~(^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sampler : per-bit edge counter, three-point capture, majority vote.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx_s,
  input  logic i_start,
  input  logic i_active,
  input  logic i_clr,
  output logic o_bit_value,
  output logic o_bit_done,
  output logic o_bit_end
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_H     = OVERSAMPLE / 2;

  localparam logic [c_CNT_W-1:0] c_S0   = c_CNT_W'(c_H - 1);
  localparam logic [c_CNT_W-1:0] c_S1   = c_CNT_W'(c_H);
  localparam logic [c_CNT_W-1:0] c_S2   = c_CNT_W'(c_H + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OVERSAMPLE - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_s0;
  logic               r_s1;
  logic               w_run;

  // The detect cycle is count 0 of the start bit, so counting begins there.
  assign w_run = i_start | i_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else begin
      if (i_clr || !w_run || (r_cnt == c_LAST)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_run && (r_cnt == c_S0)) begin
        r_s0 <= i_rx_s;
      end
      if (w_run && (r_cnt == c_S1)) begin
        r_s1 <= i_rx_s;
      end
    end
  end

  // Third sample is the live line value at the decision count.
  assign o_bit_value = (r_s0 & r_s1) | (r_s0 & i_rx_s) | (r_s1 & i_rx_s);
  assign o_bit_done  = i_active && (r_cnt == c_S2);
  assign o_bit_end   = i_active && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : oversampling UART receiver with parity and stop-bit checking.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rx_in,
  input  logic                i_par_en,
  input  logic                i_par_typ,
  output logic [c_DATA_W-1:0] o_p_data,
  output logic                o_data_valid,
  output logic                o_par_err,
  output logic                o_stp_err
);

  logic                r_sync1;
  logic                r_sync2;
  uart_state_e         r_state;
  logic [2:0]          r_bit_cnt;
  logic [c_DATA_W-1:0] r_shift;
  logic                r_par_en;
  logic                r_par_typ;
  logic                r_par_mis;
  logic [c_DATA_W-1:0] r_p_data;
  logic                r_data_valid;
  logic                r_par_err;
  logic                r_stp_err;

  logic w_detect;
  logic w_active;
  logic w_clr;
  logic w_bit_value;
  logic w_bit_done;
  logic w_bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_detect = (r_state == ST_IDLE) && !r_sync2;
  assign w_active = (r_state != ST_IDLE);
  // Counter restarts whenever the FSM heads back to IDLE mid-bit.
  assign w_clr    = w_bit_done &&
                    ((r_state == ST_STOP) || ((r_state == ST_START) && w_bit_value));

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .i_rx_s      (r_sync2),
    .i_start     (w_detect),
    .i_active    (w_active),
    .i_clr       (w_clr),
    .o_bit_value (w_bit_value),
    .o_bit_done  (w_bit_done),
    .o_bit_end   (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= c_PAR_EVEN;
      r_par_mis    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_detect) begin
            r_state   <= ST_START;
            r_par_en  <= i_par_en;
            r_par_typ <= i_par_typ ? c_PAR_ODD : c_PAR_EVEN;
            r_par_mis <= 1'b0;
            r_bit_cnt <= 3'd0;
          end
        end
        ST_START: begin
          if (w_bit_done && w_bit_value) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_shift <= {w_bit_value, r_shift[c_DATA_W-1:1]};
          end
          if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_par_mis <= (w_bit_value != f_parity(r_shift, r_par_typ));
          end
          if (w_bit_end) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at the decision point so a back-to-back start edge is caught.
          if (w_bit_done) begin
            r_state   <= ST_IDLE;
            r_par_err <= r_par_mis;
            r_stp_err <= !w_bit_value;
            if (w_bit_value && !r_par_mis) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx (vectors, corners, random).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int OS     = 8;
  localparam int H      = OS / 2;
  localparam int SYNC   = 2;                 // drive cycle -> detect cycle
  localparam int LAT_NP = 9 * OS + H + 2;
  localparam int LAT_P  = 10 * OS + H + 2;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       par_en  = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       dv;
  logic       pe;
  logic       se;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  uart_rx #(
    .OVERSAMPLE (OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_in      (rx),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_p_data     (p_data),
    .o_data_valid (dv),
    .o_par_err    (pe),
    .o_stp_err    (se)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
  } ev_t;
  ev_t ev_q[$];

  always @(negedge clk) begin
    if (dv || pe || se) ev_q.push_back('{cyc, dv, pe, se, p_data});
  end

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stop;
    bit         edv;
    bit         epe;
    bit         ese;
    logic [7:0] epd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx = 1'b1;
    end
  endtask

  task automatic drive_level(input bit v, input int n, output int s);
    s = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx = v;
      if (i == 0) s = cyc;
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                             input bit pbit, input bit stop, input bit scramble,
                             input int gbit, input int goff, output int s);
    bit b[$];
    s = -1;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pen) b.push_back(pbit);
    b.push_back(stop);
    par_en  = pen;
    par_typ = ptyp;
    foreach (b[k]) begin
      for (int j = 0; j < OS; j++) begin
        @(posedge clk); #1;
        rx = (k == gbit && j == goff) ? ~b[k] : b[k];
        if (k == 0 && j == 0) s = cyc;
        if (scramble && k == 3 && j == 0) begin
          par_en  = 1'($urandom_range(0, 1));
          par_typ = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic expect_frame(input string name, input int s, input bit pen,
                              input bit edv, input bit epe, input bit ese,
                              input logic [7:0] ed, output int at);
    ev_t ev;
    int  want;
    want = s + SYNC + (pen ? LAT_P : LAT_NP);
    at   = -1;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL %s pulse: got none, expected one at cycle %0d", name, want);
    end else begin
      ev = ev_q.pop_front();
      at = ev.at;
      check({name, " cycle"}, ev.at, want);
      check({name, " valid"}, ev.dv, edv);
      check({name, " par_err"}, ev.pe, epe);
      check({name, " stp_err"}, ev.se, ese);
      if (edv) check({name, " data"}, ev.data, ed);
    end
  endtask

  task automatic expect_quiet(input string name);
    check({name, " extra pulses"}, ev_q.size(), 0);
    ev_q.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[8];
    int         s, s2, at, at2;
    logic [7:0] model;

    vt[0] = '{8'hA5, 0, 0, 0, 1, 1, 0, 0, 8'hA5};
    vt[1] = '{8'hA5, 1, 0, 0, 1, 1, 0, 0, 8'hA5};
    vt[2] = '{8'hA5, 1, 0, 1, 1, 0, 1, 0, 8'hA5};
    vt[3] = '{8'h00, 1, 1, 1, 1, 1, 0, 0, 8'h00};
    vt[4] = '{8'h3C, 1, 1, 1, 0, 0, 0, 1, 8'h00};
    vt[5] = '{8'h0F, 1, 0, 1, 0, 0, 1, 1, 8'h00};
    vt[6] = '{8'hFF, 0, 0, 0, 1, 1, 0, 0, 8'hFF};
    vt[7] = '{8'h81, 1, 1, 1, 1, 1, 0, 0, 8'h81};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset p_data", p_data, 8'h00);
    check("reset valid", dv, 1'b0);
    check("reset par_err", pe, 1'b0);
    check("reset stp_err", se, 1'b0);
    rst = 1'b0;
    idle(2 * OS);
    expect_quiet("post reset");

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      drive_frame(vt[i].data, vt[i].pen, vt[i].ptyp, vt[i].pbit, vt[i].stop, 1'b0, -1, 0, s);
      idle(2 * OS);
      expect_frame($sformatf("vec%0d", i), s, vt[i].pen, vt[i].edv, vt[i].epe, vt[i].ese,
                   vt[i].data, at);
      check($sformatf("vec%0d p_data", i), p_data, vt[i].epd);
      expect_quiet($sformatf("vec%0d", i));
    end

    // Two-cycle low pulse in idle is rejected as a glitch
    drive_level(1'b0, 2, s);
    idle(12 * OS);
    expect_quiet("short start glitch");
    check("short glitch p_data", p_data, 8'h81);

    // One-cycle glitch on a sample point inside data bit 1
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, H - 1, s);
    idle(2 * OS);
    expect_frame("data glitch", s, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, at);
    expect_quiet("data glitch");

    // Back-to-back frames with a single stop bit
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, s);
    drive_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, s2);
    idle(2 * OS);
    expect_frame("b2b first", s, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, at);
    expect_frame("b2b second", s2, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, at2);
    check("b2b spacing", at2 - at, 10 * OS);
    expect_quiet("b2b");

    // Line held low: stop error, immediate re-detect, second stop error
    drive_level(1'b0, 2 * LAT_NP, s);
    idle(4 * OS);
    expect_frame("held low 1", s, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, at);
    expect_frame("held low 2", s + LAT_NP, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, at2);
    check("held low p_data", p_data, 8'hAA);
    expect_quiet("held low");

    // Reset in the middle of data bit 4, then a clean frame
    par_en = 1'b0;
    drive_level(1'b0, OS, s);
    drive_level(1'b1, 4 * OS + 4, s2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-frame reset p_data", p_data, 8'h00);
    check("mid-frame reset valid", dv, 1'b0);
    check("mid-frame reset par_err", pe, 1'b0);
    check("mid-frame reset stp_err", se, 1'b0);
    rst = 1'b0;
    ev_q.delete();
    idle(12 * OS);
    expect_quiet("after reset");
    drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, s);
    idle(2 * OS);
    expect_frame("after reset 0x81", s, 1'b0, 1'b1, 1'b0, 1'b0, 8'h81, at);
    expect_quiet("after reset frame");

    // Random frames against a frame-level reference model
    model = 8'h81;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit         pen, ptyp, pbit, stop, good_par, edv, epe, ese;
      d        = 8'($urandom);
      pen      = 1'($urandom_range(0, 1));
      ptyp     = 1'($urandom_range(0, 1));
      good_par = (^d) ^ ptyp;
      pbit     = ($urandom_range(0, 3) != 0) ? good_par : ~good_par;
      stop     = ($urandom_range(0, 3) != 0);
      epe      = pen && (pbit != good_par);
      ese      = !stop;
      edv      = !epe && !ese;
      if (edv) model = d;
      drive_frame(d, pen, ptyp, pbit, stop, 1'b1, -1, 0, s);
      idle(OS + int'($urandom_range(0, 2 * OS)));
      expect_frame($sformatf("rand%0d", n), s, pen, edv, epe, ese, d, at);
      check($sformatf("rand%0d p_data", n), p_data, model);
      expect_quiet($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
